// File: rtl/serial_addsub_pkg.sv
// Shared types for the digit-serial adder/subtractor.
// State encoding and operation select constants.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_n_digit_adder.sv
// Combinational DIGIT-bit adder slice.
// Also reports the carry into its top bit for overflow detection.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [DIGIT:0] t;

    assign t = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
    assign s = t[DIGIT-1:0];
    assign co = t[DIGIT];
    // sum bit = x ^ y ^ cin, so the carry into the top bit falls out
    assign c_msb_in = s[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];

endmodule

// File: rtl/serial_addsub_n.sv
// Digit-serial add/subtract, DIGIT bits per clock, WIDTH-bit result.
// Operands shift right; result digits enter at the MSB end.
module serial_addsub_n
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("serial_addsub_n: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             ovf_q;

    logic [DIGIT-1:0] d_s;
    logic             d_co;
    logic             d_cm;
    logic [WIDTH-1:0] sum_nxt;

    digit_adder #(.DIGIT(DIGIT)) u_dadd (
        .x        (a_q[DIGIT-1:0]),
        .y        (b_q[DIGIT-1:0]),
        .ci       (carry),
        .s        (d_s),
        .co       (d_co),
        .c_msb_in (d_cm)
    );

    generate
        if (DIGIT < WIDTH) begin : g_shift
            assign sum_nxt = {d_s, sum_q[WIDTH-1:DIGIT]};
        end else begin : g_whole
            assign sum_nxt = d_s;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= (mode == MODE_SUB) ? ~b : b;
                        carry  <= (mode == MODE_SUB) ? 1'b1 : cin;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sum_q <= sum_nxt;
                    a_q   <= a_q >> DIGIT;
                    b_q   <= b_q >> DIGIT;
                    carry <= d_co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cout_q <= d_co;
                        ovf_q  <= d_co ^ d_cm;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub_n.sv
// Randomised and directed bench for serial_addsub_n.
// Three instances cover DIGIT = 1, 4 and 8 at WIDTH = 8.
module tb_serial_addsub_n;

    logic       clk;
    logic       rst_n;
    logic       mode;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic       start_v [3];
    logic       busy_v  [3];
    logic       done_v  [3];
    logic [7:0] sum_v   [3];
    logic       cout_v  [3];
    logic       ovf_v   [3];

    int nlat [3] = '{8, 2, 1};
    int n_chk;
    int n_pass;

    serial_addsub_n #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode(mode),
        .a(a), .b(b), .cin(cin), .busy(busy_v[0]), .done(done_v[0]),
        .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0])
    );

    serial_addsub_n #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode(mode),
        .a(a), .b(b), .cin(cin), .busy(busy_v[1]), .done(done_v[1]),
        .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1])
    );

    serial_addsub_n #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mode(mode),
        .a(a), .b(b), .cin(cin), .busy(busy_v[2]), .done(done_v[2]),
        .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // {cout, ovf, sum} from plain integer arithmetic
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic m, input logic c);
        int r;
        int sr;
        logic co;
        logic ov;
        logic [7:0] s;
        if (m) begin
            r  = int'(x) - int'(y);
            sr = int'($signed(x)) - int'($signed(y));
            co = (x >= y);
        end else begin
            r  = int'(x) + int'(y) + int'(c);
            sr = int'($signed(x)) + int'($signed(y)) + int'(c);
            co = (r > 255);
        end
        s  = r[7:0];
        ov = (sr > 127) || (sr < -128);
        return {co, ov, s};
    endfunction

    task automatic run_op(input int idx, input logic [7:0] ta, input logic [7:0] tb,
                          input logic tm, input logic tc, input bit interfere);
        logic [9:0] e;
        int lat;
        bit seen;
        e = model(ta, tb, tm, tc);
        @(negedge clk);
        a = ta; b = tb; mode = tm; cin = tc;
        start_v[idx] = 1'b1;
        @(posedge clk);
        #1;
        start_v[idx] = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        mode = 1'($urandom); cin = 1'($urandom);
        chk("busy_after_accept", busy_v[idx], 1);
        lat = 0;
        seen = 0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (interfere && lat == 2) begin
                start_v[idx] = 1'b1;
                a = ~ta; b = ~tb; mode = ~tm;
            end
            if (interfere && lat == 3) start_v[idx] = 1'b0;
            if (done_v[idx]) seen = 1;
        end
        chk("done_seen", seen, 1);
        chk("latency", lat, nlat[idx]);
        chk("sum", sum_v[idx], e[7:0]);
        chk("cout", cout_v[idx], e[9]);
        chk("ovf", ovf_v[idx], e[8]);
        chk("busy_in_done", busy_v[idx], 1);
        @(posedge clk);
        #1;
        chk("done_one_cycle", done_v[idx], 0);
        chk("busy_idle", busy_v[idx], 0);
        chk("sum_hold", sum_v[idx], e[7:0]);
    endtask

    initial begin
        bit seen;
        int cyc;
        int d1;
        int d2;
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        mode = 1'b0; cin = 1'b0; a = '0; b = '0;
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        #12;
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", busy_v[i], 0);
            chk("rst_done", done_v[i], 0);
            chk("rst_sum", sum_v[i], 0);
            chk("rst_flags", {cout_v[i], ovf_v[i]}, 0);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;

        run_op(0, 8'h5A, 8'h33, 1'b0, 1'b0, 0);
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run_op(0, 8'h00, 8'h00, 1'b0, 1'b1, 0);
        run_op(0, 8'h10, 8'h20, 1'b1, 1'b0, 0);
        run_op(0, 8'h80, 8'h01, 1'b1, 1'b1, 0);
        run_op(1, 8'h5A, 8'h33, 1'b0, 1'b0, 0);
        run_op(2, 8'h5A, 8'h33, 1'b0, 1'b0, 0);
        run_op(0, 8'h11, 8'h22, 1'b0, 1'b0, 1);
        run_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, 0);

        // abort DIGIT=1 run at digit 3
        @(negedge clk);
        a = 8'h5A; b = 8'h33; mode = 1'b0; cin = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy_v[0], 0);
        chk("abort_sum", sum_v[0], 0);
        chk("abort_done", done_v[0], 0);
        seen = 0;
        repeat (2) begin
            @(posedge clk);
            #1 if (done_v[0]) seen = 1;
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1 if (done_v[0]) seen = 1;
        end
        chk("abort_no_done", seen, 0);
        run_op(0, 8'h01, 8'h01, 1'b0, 1'b0, 0);

        // start held high on DIGIT=4: gap between dones is N + 2
        @(negedge clk);
        a = 8'h21; b = 8'h43; mode = 1'b0; cin = 1'b1;
        start_v[1] = 1'b1;
        d1 = -1; d2 = -1; cyc = 0;
        while (d2 < 0 && cyc < 30) begin
            @(posedge clk);
            #1 cyc++;
            if (done_v[1]) begin
                if (d1 < 0) d1 = cyc;
                else begin
                    d2 = cyc;
                    start_v[1] = 1'b0;
                end
            end
        end
        start_v[1] = 1'b0;
        chk("b2b_second_done", d2 >= 0, 1);
        chk("b2b_gap", d2 - d1, 4);
        chk("b2b_sum", sum_v[1], 8'h65);
        repeat (4) @(posedge clk);
        #1 chk("b2b_stops", busy_v[1], 0);

        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < 3; i++) begin
                run_op(i, 8'($urandom), 8'($urandom), 1'($urandom),
                       1'($urandom), 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
